// File: rtl/recfg_pkg.sv
`default_nettype none
// ============================================================================
// recfg_pkg : mode and state encodings shared by the tile sequencer
// Revision  : 1.0
// ============================================================================
package recfg_pkg;

  typedef enum logic [2:0] {
    MODE_MAC      = 3'b000,
    MODE_EWM_VEC  = 3'b001,
    MODE_EWA_VEC  = 3'b010,
    MODE_OUTER    = 3'b011,
    MODE_EWA_MAT  = 3'b100,
    MODE_EWM_MAT  = 3'b101,
    MODE_EWM_MAT2 = 3'b110,
    MODE_ILLEGAL  = 3'b111
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_COMP = 3'd2,
    ST_WAIT = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

  // Systolic modes stream a second tile during COMP; all others fire once.
  function automatic logic is_systolic(input logic [2:0] mode);
    return (mode == MODE_MAC) || (mode == MODE_OUTER);
  endfunction

endpackage
`default_nettype wire

// File: rtl/recfg_tile_sched.sv
`default_nettype none
// ============================================================================
// recfg_tile_sched : command sequencer driving load/compute/wait/result phases
//                    of the 16x16 reconfigurable PE array
// Revision         : 1.0
// ============================================================================
module recfg_tile_sched
  import recfg_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int TILE_SIZE    = 16,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [2:0]                       cmd_mode,
  input  logic                             cmd_accumulate,
  input  logic                             abort,
  input  logic                             src_valid,
  output logic                             src_ready,
  input  logic [DATA_WIDTH*TILE_SIZE-1:0]  src_a,
  input  logic [DATA_WIDTH*TILE_SIZE-1:0]  src_b,
  output logic                             arr_load_en,
  output logic                             arr_valid_in,
  output logic                             arr_accumulate_en,
  output logic [2:0]                       arr_mode,
  output logic [DATA_WIDTH*TILE_SIZE-1:0]  arr_stream_a,
  output logic [DATA_WIDTH*TILE_SIZE-1:0]  arr_stream_b,
  input  logic                             arr_valid_out,
  input  logic [DATA_WIDTH*TILE_SIZE-1:0]  arr_vec_out,
  input  logic [DATA_WIDTH*TILE_SIZE-1:0]  arr_mat_out,
  input  logic                             arr_shape_flag,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [DATA_WIDTH*TILE_SIZE-1:0]  res_vec,
  output logic [DATA_WIDTH*TILE_SIZE-1:0]  res_mat,
  output logic                             res_shape,
  output logic                             busy,
  output logic                             err_mode,
  output logic                             err_timeout
);

  localparam int BEAT_W = $clog2(TILE_SIZE) + 1;
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TILE_SIZE - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_TIMEOUT - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [2:0]          r_mode;
  logic                r_accumulate;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                w_cmd_accept;
  logic                w_src_fire;
  logic                w_systolic;
  logic                w_capture;
  logic                w_mode_err;
  logic                w_timeout;

  assign arr_stream_a      = src_a;
  assign arr_stream_b      = src_b;
  assign arr_mode          = (r_state != ST_IDLE) ? r_mode : 3'b000;
  assign arr_accumulate_en = (r_state != ST_IDLE) && r_accumulate;

  always_comb begin
    w_state_next = r_state;
    w_cmd_accept = 1'b0;
    w_src_fire   = 1'b0;
    w_capture    = 1'b0;
    w_mode_err   = 1'b0;
    w_timeout    = 1'b0;
    arr_load_en  = 1'b0;
    arr_valid_in = 1'b0;
    w_systolic   = is_systolic(r_mode);

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_mode == MODE_ILLEGAL) begin
            w_mode_err = 1'b1;
          end else begin
            w_cmd_accept = 1'b1;
            w_state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        arr_load_en = src_valid;
        w_src_fire  = src_valid && src_ready;
        if (w_src_fire && (r_beat_cnt == LAST_BEAT)) w_state_next = ST_COMP;
      end
      ST_COMP: begin
        if (w_systolic) begin
          arr_valid_in = src_valid;
          w_src_fire   = src_valid && src_ready;
          if (w_src_fire && (r_beat_cnt == LAST_BEAT)) w_state_next = ST_WAIT;
        end else begin
          arr_valid_in = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A completion landing on the terminal count still wins.
        if (arr_valid_out) begin
          w_capture    = 1'b1;
          w_state_next = ST_OUT;
        end else if (r_wait_cnt == LAST_WAIT) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (res_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (abort) begin
      w_state_next = ST_IDLE;
      w_cmd_accept = 1'b0;
      w_capture    = 1'b0;
      w_mode_err   = 1'b0;
      w_timeout    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mode       <= 3'b000;
      r_accumulate <= 1'b0;
      r_beat_cnt   <= '0;
      r_wait_cnt   <= '0;
      cmd_ready    <= 1'b0;
      src_ready    <= 1'b0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_vec      <= '0;
      res_mat      <= '0;
      res_shape    <= 1'b0;
      err_mode     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      cmd_ready   <= (w_state_next == ST_IDLE);
      src_ready   <= (w_state_next == ST_LOAD) ||
                     ((w_state_next == ST_COMP) && w_systolic);
      busy        <= (w_state_next != ST_IDLE);
      res_valid   <= (w_state_next == ST_OUT);
      err_mode    <= w_mode_err;
      err_timeout <= w_timeout;

      if (w_cmd_accept) begin
        r_mode       <= cmd_mode;
        r_accumulate <= cmd_accumulate;
      end

      if (w_state_next != r_state) begin
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + BEAT_W'(w_src_fire);
      end

      if ((w_state_next != r_state) || (r_state != ST_WAIT)) begin
        r_wait_cnt <= '0;
      end else begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end

      if (w_capture) begin
        res_vec   <= arr_vec_out;
        res_mat   <= arr_mat_out;
        res_shape <= arr_shape_flag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_recfg_tile_sched.sv
`default_nettype none
// ============================================================================
// tb_recfg_tile_sched : directed bench with a result scoreboard for
//                       recfg_tile_sched
// Revision            : 1.0
// ============================================================================
module tb_recfg_tile_sched;

  localparam int DW = 16;
  localparam int TS = 16;
  localparam int VW = DW * TS;

  typedef struct {
    logic [VW-1:0] vec;
    logic [VW-1:0] mat;
    logic          shape;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_accumulate, abort;
  logic [2:0]    cmd_mode;
  logic          src_valid, src_ready;
  logic [VW-1:0] src_a, src_b;
  logic          arr_load_en, arr_valid_in, arr_accumulate_en;
  logic [2:0]    arr_mode;
  logic [VW-1:0] arr_stream_a, arr_stream_b;
  logic          arr_valid_out, arr_shape_flag;
  logic [VW-1:0] arr_vec_out, arr_mat_out;
  logic          res_valid, res_ready, res_shape;
  logic [VW-1:0] res_vec, res_mat;
  logic          busy, err_mode, err_timeout;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  int   load_cnt, vin_cnt, stall_bad;
  logic cnt_clr = 1'b1;

  recfg_tile_sched #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .WAIT_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_accumulate(cmd_accumulate), .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready), .src_a(src_a), .src_b(src_b),
    .arr_load_en(arr_load_en), .arr_valid_in(arr_valid_in),
    .arr_accumulate_en(arr_accumulate_en), .arr_mode(arr_mode),
    .arr_stream_a(arr_stream_a), .arr_stream_b(arr_stream_b),
    .arr_valid_out(arr_valid_out), .arr_vec_out(arr_vec_out),
    .arr_mat_out(arr_mat_out), .arr_shape_flag(arr_shape_flag),
    .res_valid(res_valid), .res_ready(res_ready), .res_vec(res_vec),
    .res_mat(res_mat), .res_shape(res_shape),
    .busy(busy), .err_mode(err_mode), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] ramp(input int base);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < TS; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Array activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (cnt_clr) begin
      load_cnt  = 0;
      vin_cnt   = 0;
      stall_bad = 0;
    end else begin
      if (arr_load_en) load_cnt++;
      if (arr_valid_in) vin_cnt++;
      if ((arr_load_en || (arr_valid_in && src_ready)) && !src_valid) stall_bad++;
    end
  end

  // Scoreboard monitor: every result handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", VW'(res_valid), '0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res_vec", res_vec, e.vec);
        check("res_mat", res_mat, e.mat);
        check("res_shape", VW'(res_shape), VW'(e.shape));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic issue_cmd(input logic [2:0] mode, input logic acc);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("cmd_ready_wait", VW'(cmd_ready), VW'(1));
    cmd_valid      = 1'b1;
    cmd_mode       = mode;
    cmd_accumulate = acc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic stream(input int n, input bit stall);
    int fired;
    int cyc;
    fired = 0;
    cyc   = 0;
    while (fired < n && cyc < 400) begin
      src_valid = stall ? ((cyc % 2) == 0) : 1'b1;
      src_a     = ramp(fired);
      src_b     = ramp(fired + 64);
      if (src_valid && src_ready) fired++;
      cyc++;
      tick();
    end
    src_valid = 1'b0;
    check("stream_beats", VW'(fired), VW'(n));
  endtask

  task automatic wait_pulse();
    int n;
    n = 0;
    while (!arr_valid_in && n < 50) begin
      tick();
      n++;
    end
    check("valid_in_seen", VW'(arr_valid_in), VW'(1));
  endtask

  task automatic fire_result(input logic [VW-1:0] v, input logic [VW-1:0] m, input logic s);
    exp_t e;
    e.vec = v;
    e.mat = m;
    e.shape = s;
    sb_q.push_back(e);
    arr_vec_out    = v;
    arr_mat_out    = m;
    arr_shape_flag = s;
    arr_valid_out  = 1'b1;
    tick();
    arr_valid_out  = 1'b0;
    arr_vec_out    = '0;
    arr_mat_out    = '0;
    arr_shape_flag = 1'b0;
    check("res_valid_after_out", VW'(res_valid), VW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    logic [VW-1:0] held;
    rst = 1'b1; cmd_valid = 0; cmd_mode = 0; cmd_accumulate = 0; abort = 0;
    src_valid = 0; src_a = '0; src_b = '0; arr_valid_out = 0;
    arr_vec_out = '0; arr_mat_out = '0; arr_shape_flag = 0; res_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("reset_outs", VW'({cmd_ready, src_ready, busy, res_valid, err_mode, err_timeout,
                             arr_load_en, arr_valid_in, arr_accumulate_en, arr_mode}), '0);
    src_a = ramp(3); src_b = ramp(9);
    #1;
    check("stream_a_pass", arr_stream_a, ramp(3));
    check("stream_b_pass", arr_stream_b, ramp(9));
    rst = 1'b0;
    #1;
    check("cmd_ready_before_edge", VW'(cmd_ready), '0);
    tick();
    check("cmd_ready_after_rst", VW'(cmd_ready), VW'(1));
    clear_counts();

    // Completion outside WAIT must be ignored
    arr_valid_out = 1'b1; tick(); arr_valid_out = 1'b0; tick();
    check("stray_valid_out", VW'({res_valid, busy}), '0);

    // Spatial happy path
    issue_cmd(3'b101, 1'b0);
    check("spatial_mode_out", VW'({arr_mode, arr_accumulate_en, busy}), VW'({3'b101, 1'b0, 1'b1}));
    stream(16, 1'b0);
    wait_pulse();
    tick(); tick(); tick();
    fire_result(ramp(0), ramp(100), 1'b1);
    tick();
    check("spatial_counts", VW'({8'(load_cnt), 8'(vin_cnt)}), VW'({8'd16, 8'd1}));
    check("bubble_cmd_ready", VW'({cmd_ready, res_valid, busy}), VW'({1'b1, 1'b0, 1'b0}));
    clear_counts();

    // Systolic with stalls and accumulate
    issue_cmd(3'b000, 1'b1);
    check("sys_accumulate", VW'(arr_accumulate_en), VW'(1));
    stream(32, 1'b1);
    check("sys_counts", VW'({8'(load_cnt), 8'(vin_cnt), 8'(stall_bad)}),
          VW'({8'd16, 8'd16, 8'd0}));
    fire_result(ramp(200), ramp(300), 1'b0);
    tick();
    check("acc_idle_low", VW'({arr_accumulate_en, arr_mode}), '0);
    clear_counts();

    // Illegal mode
    issue_cmd(3'b111, 1'b0);
    check("err_mode_pulse", VW'({err_mode, busy, cmd_ready}), VW'({1'b1, 1'b0, 1'b1}));
    tick();
    check("err_mode_clear", VW'(err_mode), '0);
    tick(); tick();
    check("illegal_no_load", VW'(load_cnt), '0);

    // Timeout
    issue_cmd(3'b100, 1'b0);
    stream(16, 1'b0);
    wait_pulse();
    for (int i = 0; i < 64; i++) tick();
    check("timeout_not_early", VW'({err_timeout, busy}), VW'({1'b0, 1'b1}));
    tick();
    check("timeout_pulse", VW'({err_timeout, cmd_ready, res_valid, busy}),
          VW'({1'b1, 1'b1, 1'b0, 1'b0}));
    tick();
    check("timeout_clear", VW'(err_timeout), '0);

    // Result backpressure
    res_ready = 1'b0;
    issue_cmd(3'b010, 1'b0);
    stream(16, 1'b0);
    wait_pulse();
    tick();
    fire_result(ramp(400), ramp(500), 1'b1);
    held = res_vec;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      if (!res_valid || res_vec !== held || res_shape !== 1'b1) viol++;
      tick();
    end
    check("backpressure_hold", VW'(viol), '0);
    res_ready = 1'b1;
    tick(); tick();
    check("after_handshake", VW'({res_valid, cmd_ready}), VW'({1'b0, 1'b1}));

    // Abort in LOAD after 7 beats, then a full systolic command
    issue_cmd(3'b000, 1'b0);
    stream(7, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", VW'({busy, cmd_ready, src_ready, err_mode, err_timeout}),
          VW'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    clear_counts();
    issue_cmd(3'b011, 1'b0);
    stream(32, 1'b0);
    check("post_abort_counts", VW'({8'(load_cnt), 8'(vin_cnt)}), VW'({8'd16, 8'd16}));
    fire_result(ramp(600), ramp(700), 1'b0);
    tick();

    // Asynchronous reset while in COMP
    issue_cmd(3'b110, 1'b1);
    stream(16, 1'b0);
    wait_pulse();
    #2 rst = 1'b1;
    #1;
    check("async_reset", VW'({cmd_ready, src_ready, busy, res_valid, err_mode, err_timeout,
                              arr_load_en, arr_valid_in, arr_accumulate_en, arr_mode}), '0);
    tick();
    rst = 1'b0;
    tick();
    check("ready_after_async", VW'({cmd_ready, busy}), VW'({1'b1, 1'b0}));

    tick(); tick();
    check("scoreboard_empty", VW'(sb_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
